// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: reads four bytes from a synchronous byte-wide ROM and
// assembles a big-endian 32-bit word, with a one-entry tag that suppresses refetch.
module inst_fetch_unit #(
    parameter int ADRS_W  = 10,
    parameter int ROM_LAT = 1
) (
    input  logic              clk_cpu_i,
    input  logic              reset_i,
    input  logic [31:0]       pc_i,
    input  logic              pc_valid_i,
    input  logic              flush_i,
    output logic              rom_rd_en_o,
    output logic [ADRS_W-1:0] rom_adrs_o,
    input  logic [7:0]        rom_q_i,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o,
    output logic              misaligned_o
);

    localparam int LAST = ROM_LAT - 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t              state_q;
    logic [31:0]         fpc_q;
    logic [31:0]         tag_q;
    logic [31:0]         tag_d;
    logic                tagValid_q;
    logic                tagValid_d;
    logic                instValid_d;
    logic                flushSeen_q;
    logic [1:0]          cnt_q;
    logic [1:0]          issIdx_q;
    logic [23:0]         shadow_q;
    logic [31:0]         inst_q;
    logic                instValid_q;
    logic                misaligned_q;
    logic                romRdEn_q;
    logic [ADRS_W-1:0]   romAdrs_q;
    logic [ROM_LAT-1:0]  capVld_q;
    logic [1:0]          capIdx_q [ROM_LAT];

    logic                hit;
    logic                misAccept;
    logic                complete;
    logic [1:0]          byteSel;
    logic [4:0]          byteLsb;

    assign hit       = tagValid_q && (pc_i == tag_q);
    assign misAccept = (state_q == IDLE) && pc_valid_i && !hit && (pc_i[1:0] != 2'b00);
    assign complete  = (state_q == WAIT) && capVld_q[LAST] && (capIdx_q[LAST] == 2'd3);
    assign byteSel   = 2'd2 - capIdx_q[LAST];
    assign byteLsb   = {byteSel, 3'b000};

    // inst_valid is derived from the next tag so it rises together with the new word.
    always_comb begin
        tag_d      = tag_q;
        tagValid_d = tagValid_q;
        if (misAccept) begin
            tag_d      = pc_i;
            tagValid_d = 1'b1;
        end
        if (complete) begin
            tag_d      = fpc_q;
            tagValid_d = !flushSeen_q;
        end
        if (flush_i) begin
            tagValid_d = 1'b0;
        end
        instValid_d = tagValid_d && (pc_i == tag_d);
    end

    always_ff @(posedge clk_cpu_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            fpc_q        <= '0;
            tag_q        <= '0;
            tagValid_q   <= 1'b0;
            flushSeen_q  <= 1'b0;
            cnt_q        <= '0;
            issIdx_q     <= '0;
            shadow_q     <= '0;
            inst_q       <= '0;
            instValid_q  <= 1'b0;
            misaligned_q <= 1'b0;
            romRdEn_q    <= 1'b0;
            romAdrs_q    <= '0;
            capVld_q     <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                capIdx_q[i] <= '0;
            end
        end else begin
            tag_q       <= tag_d;
            tagValid_q  <= tagValid_d;
            instValid_q <= instValid_d;

            // Each issued read travels with its byte index until rom_q carries its data.
            for (int i = ROM_LAT - 1; i > 0; i--) begin
                capVld_q[i] <= capVld_q[i-1];
                capIdx_q[i] <= capIdx_q[i-1];
            end
            capVld_q[0] <= romRdEn_q;
            capIdx_q[0] <= issIdx_q;

            if (capVld_q[LAST] && (capIdx_q[LAST] != 2'd3)) begin
                shadow_q[byteLsb +: 8] <= rom_q_i;
            end

            if (flush_i && (state_q != IDLE)) begin
                flushSeen_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (pc_valid_i && !hit) begin
                        if (pc_i[1:0] != 2'b00) begin
                            inst_q       <= '0;
                            misaligned_q <= 1'b1;
                        end else begin
                            fpc_q        <= pc_i;
                            misaligned_q <= 1'b0;
                            flushSeen_q  <= 1'b0;
                            romRdEn_q    <= 1'b1;
                            romAdrs_q    <= pc_i[ADRS_W-1:0];
                            issIdx_q     <= 2'd0;
                            cnt_q        <= 2'd1;
                            state_q      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cnt_q == 2'd0) begin
                        romRdEn_q <= 1'b0;
                        state_q   <= WAIT;
                    end else begin
                        romAdrs_q <= fpc_q[ADRS_W-1:0] + ADRS_W'(cnt_q);
                        issIdx_q  <= cnt_q;
                        cnt_q     <= cnt_q + 2'd1;
                    end
                end
                WAIT: begin
                    if (complete) begin
                        inst_q  <= {shadow_q, rom_q_i};
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rom_rd_en_o  = romRdEn_q;
    assign rom_adrs_o   = romAdrs_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = instValid_q;
    assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: one default instance (ROM_LAT=1, ADRS_W=10) and
// one with ROM_LAT=3, ADRS_W=4, both driven from the same stimulus.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pcValid;
    logic        flush;

    logic        rdEn0;
    logic [9:0]  adrs0;
    logic [7:0]  romQ0;
    logic [31:0] inst0;
    logic        instValid0;
    logic        misaligned0;

    logic        rdEn1;
    logic [3:0]  adrs1;
    logic [7:0]  romQ1;
    logic [31:0] inst1;
    logic        instValid1;
    logic        misaligned1;

    logic [7:0]  rom0 [1024];
    logic [7:0]  rom1 [16];
    logic [7:0]  romPipe1 [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetch_unit #(.ADRS_W(10), .ROM_LAT(1)) dut0 (
        .clk_cpu_i    (clk),
        .reset_i      (reset),
        .pc_i         (pc),
        .pc_valid_i   (pcValid),
        .flush_i      (flush),
        .rom_rd_en_o  (rdEn0),
        .rom_adrs_o   (adrs0),
        .rom_q_i      (romQ0),
        .inst_o       (inst0),
        .inst_valid_o (instValid0),
        .misaligned_o (misaligned0)
    );

    inst_fetch_unit #(.ADRS_W(4), .ROM_LAT(3)) dut1 (
        .clk_cpu_i    (clk),
        .reset_i      (reset),
        .pc_i         (pc),
        .pc_valid_i   (pcValid),
        .flush_i      (flush),
        .rom_rd_en_o  (rdEn1),
        .rom_adrs_o   (adrs1),
        .rom_q_i      (romQ1),
        .inst_o       (inst1),
        .inst_valid_o (instValid1),
        .misaligned_o (misaligned1)
    );

    // ROM models: data appears ROM_LAT cycles after the address is presented.
    always @(posedge clk) begin
        romQ0 <= rom0[adrs0];
    end

    always @(posedge clk) begin
        romPipe1[0] <= rom1[adrs1];
        romPipe1[1] <= romPipe1[0];
        romPipe1[2] <= romPipe1[1];
    end

    assign romQ1 = romPipe1[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic [31:0] pcIn, input logic pcV,
                                 input logic fl);
        reset   = rst;
        pc      = pcIn;
        pcValid = pcV;
        flush   = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        logic anyRd;
        logic anyInvalid;

        for (int i = 0; i < 1024; i++) rom0[i] = 8'hFF;
        for (int i = 0; i < 16; i++) rom1[i] = 8'hEE;
        rom0[0]  = 8'h24; rom0[1]  = 8'h08; rom0[2]  = 8'h00; rom0[3]  = 8'h05;
        rom0[4]  = 8'hAC; rom0[5]  = 8'h09; rom0[6]  = 8'h00; rom0[7]  = 8'h10;
        rom0[8]  = 8'h8C; rom0[9]  = 8'h0A; rom0[10] = 8'h00; rom0[11] = 8'h14;
        rom1[12] = 8'h3C; rom1[13] = 8'h01; rom1[14] = 8'h12; rom1[15] = 8'h34;

        // Test 1: reset state, then the first fetch of pc=0
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("rstInst", inst0, 32'h0);
        checkOutput("rstValid", {31'b0, instValid0}, 32'd0);
        checkOutput("rstMis", {31'b0, misaligned0}, 32'd0);
        checkOutput("rstRdEn", {31'b0, rdEn0}, 32'd0);
        checkOutput("rstAdrs", {22'b0, adrs0}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("t1RdEn", {31'b0, rdEn0}, 32'd1);
            checkOutput("t1Adrs", {22'b0, adrs0}, k);
        end
        tick();
        checkOutput("t1ValidEarly", {31'b0, instValid0}, 32'd0);
        checkOutput("t1RdEnOff", {31'b0, rdEn0}, 32'd0);
        tick();
        checkOutput("t1Inst", inst0, 32'h24080005);
        checkOutput("t1Valid", {31'b0, instValid0}, 32'd1);

        // Test 2: hold pc, no refetch; then move to pc=4
        anyRd      = 1'b0;
        anyInvalid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            anyRd      = anyRd | rdEn0;
            anyInvalid = anyInvalid | !instValid0;
        end
        checkOutput("t2NoRefetch", {31'b0, anyRd}, 32'd0);
        checkOutput("t2StaysValid", {31'b0, anyInvalid}, 32'd0);
        applyStimulus(1'b0, 32'h4, 1'b1, 1'b0);
        tick();
        checkOutput("t2ValidDrop", {31'b0, instValid0}, 32'd0);
        checkOutput("t2RdEn", {31'b0, rdEn0}, 32'd1);
        checkOutput("t2Adrs", {22'b0, adrs0}, 32'd4);
        repeat (4) tick();
        checkOutput("t2ValidEarly", {31'b0, instValid0}, 32'd0);
        tick();
        checkOutput("t2Inst", inst0, 32'hAC090010);
        checkOutput("t2Valid", {31'b0, instValid0}, 32'd1);

        // Test 3: flush forces refetch of 4, pc moves to 8 on the 2nd ISSUE cycle
        applyStimulus(1'b0, 32'h4, 1'b1, 1'b1);
        tick();
        checkOutput("t3FlushValid", {31'b0, instValid0}, 32'd0);
        applyStimulus(1'b0, 32'h4, 1'b1, 1'b0);
        tick();
        checkOutput("t3Adrs0", {22'b0, adrs0}, 32'd4);
        tick();
        checkOutput("t3Adrs1", {22'b0, adrs0}, 32'd5);
        applyStimulus(1'b0, 32'h8, 1'b1, 1'b0);
        repeat (4) tick();
        checkOutput("t3OldInst", inst0, 32'hAC090010);
        checkOutput("t3OldValid", {31'b0, instValid0}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("t3RdEn", {31'b0, rdEn0}, 32'd1);
            checkOutput("t3Adrs", {22'b0, adrs0}, 32'd8 + k);
        end
        tick();
        checkOutput("t3ValidEarly", {31'b0, instValid0}, 32'd0);
        tick();
        checkOutput("t3Inst", inst0, 32'h8C0A0014);
        checkOutput("t3Valid", {31'b0, instValid0}, 32'd1);

        // Test 4: misaligned pc=6, then aligned pc=8
        applyStimulus(1'b0, 32'h6, 1'b1, 1'b0);
        tick();
        checkOutput("t4Mis", {31'b0, misaligned0}, 32'd1);
        checkOutput("t4Inst", inst0, 32'h0);
        checkOutput("t4Valid", {31'b0, instValid0}, 32'd1);
        checkOutput("t4RdEn", {31'b0, rdEn0}, 32'd0);
        tick();
        checkOutput("t4RdEnHold", {31'b0, rdEn0}, 32'd0);
        applyStimulus(1'b0, 32'h8, 1'b1, 1'b0);
        tick();
        checkOutput("t4MisClear", {31'b0, misaligned0}, 32'd0);
        checkOutput("t4RdEn8", {31'b0, rdEn0}, 32'd1);
        checkOutput("t4Adrs8", {22'b0, adrs0}, 32'd8);
        repeat (5) tick();
        checkOutput("t4Inst8", inst0, 32'h8C0A0014);
        checkOutput("t4Valid8", {31'b0, instValid0}, 32'd1);

        // Test 5: reset on the 3rd ISSUE cycle, then a clean refetch
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("t5Adrs2", {22'b0, adrs0}, 32'd2);
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("t5RstInst", inst0, 32'h0);
        checkOutput("t5RstValid", {31'b0, instValid0}, 32'd0);
        checkOutput("t5RstMis", {31'b0, misaligned0}, 32'd0);
        checkOutput("t5RstRdEn", {31'b0, rdEn0}, 32'd0);
        checkOutput("t5RstAdrs", {22'b0, adrs0}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("t5Adrs", {22'b0, adrs0}, k);
        end
        tick();
        checkOutput("t5NoStale", inst0, 32'h0);
        tick();
        checkOutput("t5Inst", inst0, 32'h24080005);
        checkOutput("t5Valid", {31'b0, instValid0}, 32'd1);

        // Test 6: ROM_LAT=3, ADRS_W=4 instance
        applyStimulus(1'b1, 32'h0E, 1'b1, 1'b0);
        tick();
        checkOutput("t6RstValid", {31'b0, instValid1}, 32'd0);
        checkOutput("t6RstRdEn", {31'b0, rdEn1}, 32'd0);
        applyStimulus(1'b0, 32'h0E, 1'b1, 1'b0);
        tick();
        checkOutput("t6Mis", {31'b0, misaligned1}, 32'd1);
        checkOutput("t6MisInst", inst1, 32'h0);
        checkOutput("t6MisValid", {31'b0, instValid1}, 32'd1);
        checkOutput("t6MisRdEn", {31'b0, rdEn1}, 32'd0);
        applyStimulus(1'b0, 32'h0C, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("t6RdEn", {31'b0, rdEn1}, 32'd1);
            checkOutput("t6Adrs", {28'b0, adrs1}, 32'hC + k);
        end
        checkOutput("t6MisClear", {31'b0, misaligned1}, 32'd0);
        repeat (3) tick();
        checkOutput("t6ValidEarly", {31'b0, instValid1}, 32'd0);
        tick();
        checkOutput("t6Inst", inst1, 32'h3C011234);
        checkOutput("t6Valid", {31'b0, instValid1}, 32'd1);
        applyStimulus(1'b0, 32'h0C, 1'b1, 1'b1);
        tick();
        checkOutput("t6FlushValid", {31'b0, instValid1}, 32'd0);
        applyStimulus(1'b0, 32'h0C, 1'b1, 1'b0);
        tick();
        checkOutput("t6RefetchRdEn", {31'b0, rdEn1}, 32'd1);
        checkOutput("t6RefetchAdrs", {28'b0, adrs1}, 32'hC);
        repeat (7) tick();
        checkOutput("t6RefetchInst", inst1, 32'h3C011234);
        checkOutput("t6RefetchValid", {31'b0, instValid1}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
